fsm_k_burst: RTL and testbench
==============================

Name: fsm_k_burst

Overview:
- Parametrised successor of the FSM k read controller (go/ws in; rd/ds out).
- Adds multi-beat bursts, a programmable delay per beat, bounded wait-state retries with an error exit, and abort.
- Sits between a transaction requester and a slow read port.
- Moore style: all outputs decode from registered state and counters.

Parameters:
- BEAT_W, 4, width of burst_len and beat_cnt; a burst is burst_len+1 beats, so 1..2^BEAT_W beats.
- DLY_W, 3, width of dly_cycles; the DLY phase lasts dly_cycles+1 cycles.
- MAX_RETRY, 3, number of consecutive ws-high retries allowed per beat before the error exit; valid range 1..255.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- go, input, 1, start request, sampled only in IDLE.
- ws, input, 1, wait-state, sampled on the last DLY cycle of each beat.
- abort, input, 1, cancels an active burst.
- burst_len, input, BEAT_W, beats minus 1, latched when go is accepted.
- dly_cycles, input, DLY_W, extra DLY cycles per beat, latched when go is accepted.
- rd, output, 1, read strobe.
- ds, output, 1, done strobe.
- err, output, 1, retry-limit error strobe.
- busy, output, 1, high whenever the FSM is not in IDLE.
- beat_cnt, output, BEAT_W, number of completed beats in the current or last burst.

Behaviour:
- Reset and clocking:
  - One clock domain, clk.
  - Reset is synchronous and active-high (rst).
  - rst high at a rising edge forces state=IDLE and clears all counters and latched fields.
  - During and after reset: rd=0, ds=0, err=0, busy=0, beat_cnt=0.
  - Reset mid-burst abandons the burst immediately; no ds and no err are issued.
- States: IDLE, READ, DLY, DONE, ERR. Output decode:
  - rd=1 in READ and DLY.
  - ds=1 in DONE only.
  - err=1 in ERR only.
  - busy=1 in every state except IDLE.
- IDLE:
  - go=1 → READ.
  - On that same edge: latch burst_len and dly_cycles; clear beat_cnt, the retry counter and the delay counter.
  - go=0 → stay in IDLE. beat_cnt holds its last value.
- READ:
  - Lasts exactly 1 cycle, then → DLY.
  - Clear the delay counter on entry.
- DLY:
  - The delay counter increments each cycle.
  - On the cycle where the counter equals the latched dly_cycles (the last DLY cycle), sample ws:
    - ws=1 and retries < MAX_RETRY: increment the retry counter, → READ, same beat (beat_cnt unchanged).
    - ws=1 and retries == MAX_RETRY: → ERR.
    - ws=0: beat_cnt+1 and clear the retry counter. If the completed beat was the last one (beat_cnt == latched burst_len before the increment) → DONE, otherwise → READ.
  - ws is ignored on every other DLY cycle.
- DONE: lasts 1 cycle, then → IDLE. go is not sampled in DONE.
- ERR: lasts 1 cycle, then → IDLE. beat_cnt keeps the number of beats that completed before the error.
- abort:
  - abort=1 in READ or DLY → IDLE on the next edge. No ds, no err; beat_cnt is held.
  - abort takes priority over ws and over the end-of-burst condition on the same cycle.
  - abort is ignored in IDLE, DONE and ERR.
  - abort=1 together with go=1 in IDLE: go wins (abort is ignored).
- Latency with all defaults (burst_len=0, dly_cycles=0, ws=0):
  - go accepted at edge E0: READ in E0..E1, DLY in E1..E2, DONE in E2..E3, IDLE again from E3.
  - Cycle for cycle this is the original FSM k Moore behaviour.
- Per-beat cost: 1 READ cycle + (dly_cycles+1) DLY cycles, plus the same again for each retry.
- Counter widths:
  - beat_cnt is BEAT_W bits. With burst_len=2^BEAT_W−1 it wraps to 0 on the final increment; this is permitted, and DONE is still reached because the last-beat compare uses the value before the increment.
  - The retry counter is ceil(log2(MAX_RETRY+1)) bits; it must never wrap.
- burst_len and dly_cycles changing while busy=1 have no effect, because only the latched copies are used.

Test Plan:
- Reset and default read:
  - Assert rst for 2 cycles: all outputs 0.
  - Then go=1 for 1 cycle with burst_len=0, dly_cycles=0, ws=0.
  - Required: rd=1 for exactly 2 cycles, ds=1 on the 3rd cycle, busy=0 on the 4th, beat_cnt=1.
- Burst with delay:
  - burst_len=2, dly_cycles=1, ws=0.
  - Required: the rd high-time covers 3 beats of 3 cycles each (9 cycles), then a ds pulse 1 cycle wide, and beat_cnt=3.
- Retry then succeed:
  - burst_len=0, dly_cycles=0; ws=1 on the first 2 DLY samples, then ws=0.
  - Required: 3 READ entries, rd high for 6 cycles, ds pulse, err never high.
- Retry limit:
  - MAX_RETRY=3, ws held at 1.
  - Required: 4 READ entries, then err=1 for 1 cycle, ds stays 0, beat_cnt=0, return to IDLE.
- Abort mid-burst:
  - burst_len=3, dly_cycles=0; abort=1 in the DLY cycle of beat 2 with ws=0 on that same cycle.
  - Required: IDLE on the next cycle, no ds, beat_cnt=1.
- Synchronous reset mid-burst:
  - Assert rst during DLY of beat 1 of a 4-beat burst.
  - Required: after the edge, rd=0, busy=0, beat_cnt=0, and no ds or err pulse.
  - A following go=1 starts a clean burst.

Source files
------------

// File: rtl/fsm_k_burst.sv
// Burst read controller: multi-beat reads with per-beat delay, bounded
// wait-state retries with an error exit, and abort. Moore outputs.
module fsm_k_burst #(
    parameter int unsigned BEAT_W    = 4,
    parameter int unsigned DLY_W     = 3,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              ws,
    input  logic              abort,
    input  logic [BEAT_W-1:0] burst_len,
    input  logic [DLY_W-1:0]  dly_cycles,
    output logic              rd,
    output logic              ds,
    output logic              err,
    output logic              busy,
    output logic [BEAT_W-1:0] beat_cnt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_DLY  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
    logic [BEAT_W-1:0]   len_q, len_d;
    logic [DLY_W-1:0]    dly_lim_q, dly_lim_d;
    logic                rd_d, ds_d, err_d, busy_d;

    // Next state, counter updates and output decode of the next state
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_cnt;
        retry_d   = retry_q;
        dly_cnt_d = dly_cnt_q;
        len_d     = len_q;
        dly_lim_d = dly_lim_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_READ;
                    len_d     = burst_len;
                    dly_lim_d = dly_cycles;
                    beat_d    = '0;
                    retry_d   = '0;
                    dly_cnt_d = '0;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_DLY;
                    dly_cnt_d = '0;
                end
            end
            S_DLY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dly_cnt_q == dly_lim_q) begin
                    // last delay cycle: ws decides retry, error or beat completion
                    if (ws) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_READ;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        beat_d  = beat_cnt + 1'b1;
                        retry_d = '0;
                        state_d = (beat_cnt == len_q) ? S_DONE : S_READ;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_d   = (state_d == S_READ) || (state_d == S_DLY);
        ds_d   = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        busy_d = (state_d != S_IDLE);
    end

    // State, counters, latched fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_cnt  <= '0;
            retry_q   <= '0;
            dly_cnt_q <= '0;
            len_q     <= '0;
            dly_lim_q <= '0;
            rd        <= 1'b0;
            ds        <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_cnt  <= beat_d;
            retry_q   <= retry_d;
            dly_cnt_q <= dly_cnt_d;
            len_q     <= len_d;
            dly_lim_q <= dly_lim_d;
            rd        <= rd_d;
            ds        <= ds_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fsm_k_burst.sv
// Bench for fsm_k_burst: a timeline model expands each transaction into
// per-cycle stimulus and expected outputs; literal totals pin the model.
module tb_fsm_k_burst;

    localparam int unsigned BEAT_W    = 4;
    localparam int unsigned DLY_W     = 3;
    localparam int unsigned MAX_RETRY = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              go = 1'b0;
    logic              ws = 1'b0;
    logic              abort = 1'b0;
    logic [BEAT_W-1:0] burst_len = '0;
    logic [DLY_W-1:0]  dly_cycles = '0;
    logic              rd, ds, err, busy;
    logic [BEAT_W-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       go;
        logic       ws;
        logic       abort;
        logic       rst;
        logic       rd;
        logic       ds;
        logic       err;
        logic       busy;
        logic [3:0] beat;
    } rec_t;

    rec_t q[$];
    int   prev_beat = 0;

    fsm_k_burst #(
        .BEAT_W(BEAT_W),
        .DLY_W(DLY_W),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .ws(ws),
        .abort(abort),
        .burst_len(burst_len),
        .dly_cycles(dly_cycles),
        .rd(rd),
        .ds(ds),
        .err(err),
        .busy(busy),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_idle(input int b);
        rec_t r;
        r = '0;
        r.abort = 1'($urandom);
        r.beat = 4'(b);
        q.push_back(r);
    endtask

    // DONE/ERR cycle (abort there must be ignored), then back to idle
    task automatic push_term(input logic d, input logic e, input int b);
        rec_t r;
        r = '0;
        r.ds = d;
        r.err = e;
        r.busy = 1'b1;
        r.abort = 1'b1;
        r.beat = 4'(b);
        q.push_back(r);
        push_idle(b);
    endtask

    // Expand one transaction into its cycle timeline.
    // Each beat attempt = 1 READ cycle + (dly+1) DLY cycles; ws counts on the last.
    task automatic build(input int len, input int dly, input logic [31:0] plan,
                         input int abort_at, input int rst_at, input logic go_abort);
        rec_t r;
        int beats, retries, sample;
        bit fin;
        logic w;
        beats = 0; retries = 0; sample = 0; fin = 0;
        q.delete();
        r = '0;
        r.go = 1'b1;
        r.abort = go_abort;
        r.beat = 4'(prev_beat);
        q.push_back(r);
        while (!fin && q.size() < 2000) begin
            for (int d = -1; d <= dly && !fin; d++) begin
                r = '0;
                r.rd = 1'b1;
                r.busy = 1'b1;
                r.beat = 4'(beats);
                if (d == dly) begin
                    w = plan[sample];
                    sample++;
                end else begin
                    w = 1'($urandom);
                end
                r.ws = w;
                if (q.size() == abort_at) begin
                    r.abort = 1'b1;
                    q.push_back(r);
                    push_idle(beats);
                    fin = 1;
                end else if (q.size() == rst_at) begin
                    r.rst = 1'b1;
                    q.push_back(r);
                    push_idle(0);
                    fin = 1;
                end else begin
                    q.push_back(r);
                    if (d == dly) begin
                        if (w) begin
                            if (retries < int'(MAX_RETRY)) retries++;
                            else begin
                                push_term(1'b0, 1'b1, beats);
                                fin = 1;
                            end
                        end else begin
                            beats++;
                            retries = 0;
                            if (beats == len + 1) begin
                                push_term(1'b1, 1'b0, beats);
                                fin = 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Drive the timeline, compare every cycle, then check literal totals
    task automatic run(input string tag, input int len, input int dly, input logic [31:0] plan,
                       input int abort_at, input int rst_at, input logic go_abort,
                       input int exp_rd, input int exp_ds, input int exp_err, input int exp_beat);
        rec_t r;
        int n_rd, n_ds, n_err;
        n_rd = 0; n_ds = 0; n_err = 0;
        build(len, dly, plan, abort_at, rst_at, go_abort);
        for (int i = 0; i < q.size(); i++) begin
            r = q[i];
            go = r.go;
            ws = r.ws;
            abort = r.abort;
            rst = r.rst;
            burst_len = (i == 0) ? BEAT_W'(len) : BEAT_W'($urandom);
            dly_cycles = (i == 0) ? DLY_W'(dly) : DLY_W'($urandom);
            @(negedge clk);
            chk({tag, " rd"}, int'(rd), int'(r.rd));
            chk({tag, " ds"}, int'(ds), int'(r.ds));
            chk({tag, " err"}, int'(err), int'(r.err));
            chk({tag, " busy"}, int'(busy), int'(r.busy));
            chk({tag, " beat_cnt"}, int'(beat_cnt), int'(r.beat));
            n_rd += int'(rd);
            n_ds += int'(ds);
            n_err += int'(err);
            @(posedge clk);
            #1;
        end
        go = 1'b0; ws = 1'b0; abort = 1'b0; rst = 1'b0;
        prev_beat = int'(q[q.size()-1].beat);
        chk({tag, " rd_cycles"}, n_rd, exp_rd);
        chk({tag, " ds_pulses"}, n_ds, exp_ds);
        chk({tag, " err_pulses"}, n_err, exp_err);
        chk({tag, " final_beat"}, int'(beat_cnt), exp_beat);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset rd", int'(rd), 0);
        chk("reset ds", int'(ds), 0);
        chk("reset err", int'(err), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset beat_cnt", int'(beat_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_beat = 0;

        //   tag         len dly plan          abort rst  goab rd  ds err beat
        run("default",   0,  0,  32'h0,        -1,   -1,  0,   2,  1, 0,  1);
        run("burst_dly", 2,  1,  32'h0,        -1,   -1,  0,   9,  1, 0,  3);
        run("retry_ok",  0,  0,  32'b011,      -1,   -1,  0,   6,  1, 0,  1);
        run("retry_max", 0,  0,  32'hFFFFFFFF, -1,   -1,  0,   8,  0, 1,  0);
        run("abort",     3,  0,  32'h0,        4,    -1,  0,   4,  0, 0,  1);
        run("sync_rst",  3,  0,  32'h0,        -1,   2,   0,   2,  0, 0,  0);
        run("after_rst", 1,  2,  32'h0,        -1,   -1,  0,   8,  1, 0,  2);
        run("wrap",      15, 0,  32'h0,        -1,   -1,  0,   32, 1, 0,  0);
        run("go_abort",  0,  0,  32'h0,        -1,   -1,  1,   2,  1, 0,  1);
        run("mix",       1,  1,  32'b0010,     -1,   -1,  0,   9,  1, 0,  2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
